// File: rtl/edge_event_detector.sv
// ---------------------------------------------------------------------------
// edge_event_detector
//
// Multi-channel edge/event detector for asynchronous digital inputs. Each
// channel is synchronised, debounced by a consecutive-cycle filter, and
// classified into rising/falling events that raise a one-cycle pulse, set a
// sticky flag and bump a saturating event counter. A single interrupt line
// reports any channel with its sticky flag set.
//
// Parameters
//   N_CH        number of independent channels (1..32)
//   SYNC_STAGES synchroniser depth per channel (2..4)
//   FILT_CYC    consecutive mismatching cycles needed to accept a change (1..255)
//   CNT_W       width of each per-channel event counter (1..16)
//
// Ports
//   clk     clock, all state changes on the rising edge
//   rst_n   asynchronous active-low reset
//   din     raw asynchronous inputs, one bit per channel
//   mode    edge select per channel at [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
//   clr     per-channel synchronous clear of sticky flag and counter
//   level   filtered, synchronised level per channel
//   pulse   one-cycle event strobe per channel
//   sticky  latched event flag per channel
//   cnt     per-channel event count, channel i at [(i+1)*CNT_W-1:i*CNT_W]
//   irq     OR of all sticky flags
// ---------------------------------------------------------------------------
module edge_event_detector #(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYC    = 3,
  parameter int CNT_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       din,
  input  logic [2*N_CH-1:0]     mode,
  input  logic [N_CH-1:0]       clr,
  output logic [N_CH-1:0]       level,
  output logic [N_CH-1:0]       pulse,
  output logic [N_CH-1:0]       sticky,
  output logic [N_CH*CNT_W-1:0] cnt,
  output logic                  irq
);

  // Filter counter is just wide enough to hold FILT_CYC.
  localparam int FW = $clog2(FILT_CYC + 1);

  // The counter never actually stores FILT_CYC: the cycle that would reach
  // it toggles the level and clears instead, so the last stored value is
  // FILT_CYC-1.
  localparam logic [FW-1:0]    FILT_LAST = FW'(FILT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_sel_e;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   samp;
    logic [FW-1:0]          filt_q;
    logic                   level_q;
    logic                   toggle;
    edge_sel_e              edge_sel;
    logic                   ev_hit;
    logic                   ev_q;
    logic                   pulse_q;
    logic                   sticky_q;
    logic [CNT_W-1:0]       cnt_q;

    // Synchroniser chain: din enters at bit 0, the last stage is the
    // sample the filter works on.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], din[i]};
      end
    end

    assign samp = sync_q[SYNC_STAGES-1];

    // A level change is accepted on the cycle the mismatch count would
    // reach FILT_CYC; any matching cycle in between restarts the count.
    assign toggle = (samp != level_q) && (filt_q == FILT_LAST);

    // Debounce filter and the accepted level.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        filt_q  <= '0;
        level_q <= 1'b0;
      end else if (samp == level_q) begin
        filt_q  <= '0;
      end else if (toggle) begin
        filt_q  <= '0;
        level_q <= ~level_q;
      end else begin
        filt_q  <= filt_q + FW'(1);
      end
    end

    // Classify the change on the very edge where level toggles, using the
    // mode present on that edge, so a later mode change can never create a
    // pulse for a change that already happened.
    always_comb begin
      edge_sel = edge_sel_e'(mode[2*i +: 2]);
      ev_hit   = 1'b0;
      if (toggle) begin
        case (edge_sel)
          EDGE_RISE: ev_hit = ~level_q;
          EDGE_FALL: ev_hit = level_q;
          EDGE_BOTH: ev_hit = 1'b1;
          default:   ev_hit = 1'b0;
        endcase
      end
    end

    // ev_q is high in the same cycle the new level is visible; pulse is
    // one register later, i.e. the cycle after the level change.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ev_q    <= 1'b0;
        pulse_q <= 1'b0;
      end else begin
        ev_q    <= ev_hit;
        pulse_q <= ev_q;
      end
    end

    // Sticky flag: a pulse sets it, clr clears it, and a pulse coinciding
    // with clr leaves it set so that event is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sticky_q <= 1'b0;
      end else if (pulse_q) begin
        sticky_q <= 1'b1;
      end else if (clr[i]) begin
        sticky_q <= 1'b0;
      end
    end

    // Saturating event counter. A clear that coincides with a pulse counts
    // that pulse, leaving the counter at 1.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else if (clr[i]) begin
        cnt_q <= pulse_q ? CNT_W'(1) : '0;
      end else if (pulse_q && (cnt_q != CNT_MAX)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end

    assign level[i]               = level_q;
    assign pulse[i]               = pulse_q;
    assign sticky[i]              = sticky_q;
    assign cnt[i*CNT_W +: CNT_W]  = cnt_q;

  end : g_ch

  // Purely combinational so the interrupt follows sticky with no delay.
  assign irq = |sticky;

endmodule
